// File: rtl/wb_arbiter.sv
// Write-back arbiter in front of the register file's single write port.
// Merges the in-order pipeline write-back with long-latency results held in a
// small FIFO, keeps a pending-register bitmap for the hazard logic, and raises
// stall_req when the FIFO has been blocked by the pipeline for too long.
//
// Long-latency handshake: an entry {lu_wa, lu_wd} is transferred on every
// rising edge where lu_valid && lu_ready. lu_ready depends only on FIFO
// occupancy (and reset), never on lu_valid. The producer must hold
// lu_valid/lu_wa/lu_wd stable until the transfer happens.
module wb_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_we,
  input  logic [4:0]       pipe_wa,
  input  logic [WIDTH-1:0] pipe_wd,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [4:0]       lu_wa,
  input  logic [WIDTH-1:0] lu_wd,
  input  logic             iss_valid,
  input  logic [4:0]       iss_wa,
  output logic [31:0]      pend,
  output logic             stall_req,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [WIDTH-1:0] rf_wd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_FIFO = 2'd2
  } sel_t;

  sel_t             sel;
  logic [4:0]       fifo_wa [DEPTH];
  logic [WIDTH-1:0] fifo_wd [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [SW-1:0]    starve_cnt;
  logic [SW-1:0]    starve_next;
  logic [31:0]      pend_next;
  logic             fifo_ne;
  logic             push;
  logic             pop;
  logic [4:0]       head_wa;
  logic [WIDTH-1:0] head_wd;

  assign lu_ready = !rst && (count < DEPTH_C);
  assign push     = lu_valid && lu_ready;
  assign fifo_ne  = (count != '0);
  assign head_wa  = fifo_wa[rd_ptr];
  assign head_wd  = fifo_wd[rd_ptr];
  assign pop      = (sel == SEL_FIFO);

  // Arbitration: a starved FIFO first, then a real pipeline write, then the FIFO.
  always_comb begin
    sel = SEL_IDLE;
    if (stall_req && fifo_ne) begin
      sel = SEL_FIFO;
    end else if (pipe_we && (pipe_wa != 5'd0)) begin
      sel = SEL_PIPE;
    end else if (fifo_ne) begin
      sel = SEL_FIFO;
    end
  end

  // FIFO storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa[wr_ptr] <= lu_wa;
      fifo_wd[wr_ptr] <= lu_wd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation count: grows while the pipeline blocks a non-empty FIFO.
  always_comb begin
    starve_next = starve_cnt;
    if (!fifo_ne || pop) begin
      starve_next = '0;
    end else if ((sel == SEL_PIPE) && (starve_cnt != STARVE_C)) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  // Starvation counter and the registered stall request derived from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_req  <= (starve_next == STARVE_C);
    end
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= 5'd0;
      rf_wd <= '0;
    end else begin
      case (sel)
        SEL_PIPE: begin
          rf_we <= 1'b1;
          rf_wa <= pipe_wa;
          rf_wd <= pipe_wd;
        end
        SEL_FIFO: begin
          rf_we <= (head_wa != 5'd0);
          rf_wa <= head_wa;
          rf_wd <= head_wd;
        end
        default: begin
          rf_we <= 1'b0;
        end
      endcase
    end
  end

  // Pending bitmap: clear on drain, set on issue (set wins), x0 never pending.
  always_comb begin
    pend_next = pend;
    if (pop) begin
      pend_next[head_wa] = 1'b0;
    end
    if (iss_valid && (iss_wa != 5'd0)) begin
      pend_next[iss_wa] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  // Pending bitmap register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a short random
// pipeline burst; every register-file write is matched against exp_q.
module tb_wb_arbiter;

  localparam int WIDTH = 32;
  localparam int EW    = 5 + WIDTH;

  logic             clk;
  logic             rst;
  logic             pipe_we;
  logic [4:0]       pipe_wa;
  logic [WIDTH-1:0] pipe_wd;
  logic             lu_valid;
  logic             lu_ready;
  logic [4:0]       lu_wa;
  logic [WIDTH-1:0] lu_wd;
  logic             iss_valid;
  logic [4:0]       iss_wa;
  logic [31:0]      pend;
  logic             stall_req;
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic [WIDTH-1:0] rf_wd;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  wb_arbiter #(.WIDTH(WIDTH), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_wa   (pipe_wa),
    .pipe_wd   (pipe_wd),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_wa     (lu_wa),
    .lu_wd     (lu_wd),
    .iss_valid (iss_valid),
    .iss_wa    (iss_wa),
    .pend      (pend),
    .stall_req (stall_req),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks; inputs change at the falling edge, DUT samples at the rising edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    pipe_we   = 1'b0;
    pipe_wa   = 5'd0;
    pipe_wd   = '0;
    lu_valid  = 1'b0;
    lu_wa     = 5'd0;
    lu_wd     = '0;
    iss_valid = 1'b0;
    iss_wa    = 5'd0;
  endtask

  task automatic drive_pipe(input logic [4:0] wa, input logic [WIDTH-1:0] wd, input bit expect_it);
    pipe_we = 1'b1;
    pipe_wa = wa;
    pipe_wd = wd;
    if (expect_it && wa != 5'd0) exp_q.push_back({wa, wd});
  endtask

  task automatic drive_lu(input logic [4:0] wa, input logic [WIDTH-1:0] wd, input bit expect_it);
    lu_valid = 1'b1;
    lu_wa    = wa;
    lu_wd    = wd;
    if (expect_it && wa != 5'd0) exp_q.push_back({wa, wd});
  endtask

  // Scoreboard: every register-file write must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rf_unexpected_we", rf_we, 1'b0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("rf_write", {rf_wa, rf_wd}, e);
      end
    end
  end

  initial begin
    logic [4:0]       wa;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] d_ent [3];
    logic [4:0]       x_wa;
    logic [WIDTH-1:0] x_wd;
    int idx;
    bit acc;

    rst = 1'b1;
    idle_inputs();
    cyc(3);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_wa", rf_wa, 5'd0);
    check("rst_rf_wd", rf_wd, 32'd0);
    check("rst_pend", pend, 32'd0);
    check("rst_stall", stall_req, 1'b0);
    check("rst_lu_ready", lu_ready, 1'b0);
    rst = 1'b0;
    cyc(1);
    check("post_rst_lu_ready", lu_ready, 1'b1);

    // Pipeline write, one-edge latency, then idle
    drive_pipe(5'd5, 32'hDEADBEEF, 1'b1);
    cyc(1);
    pipe_we = 1'b0;
    check("t1_we", rf_we, 1'b1);
    check("t1_wa", rf_wa, 5'd5);
    check("t1_wd", rf_wd, 32'hDEADBEEF);
    cyc(1);
    check("t1_we_off", rf_we, 1'b0);

    // Random pipeline burst, including wa=0 no-writes
    for (int i = 0; i < 10; i++) begin
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      if ($urandom_range(0, 1) == 1) drive_pipe(wa, wd, 1'b1);
      else pipe_we = 1'b0;
      cyc(1);
    end
    pipe_we = 1'b0;
    cyc(1);

    // Issue x7, push its result later; pend cleared as rf_* presents it
    iss_valid = 1'b1;
    iss_wa    = 5'd7;
    cyc(1);
    iss_valid = 1'b0;
    check("t2_pend7_set", pend[7], 1'b1);
    cyc(2);
    drive_lu(5'd7, 32'h12, 1'b1);
    cyc(1);
    lu_valid = 1'b0;
    check("t2_no_passthru", rf_we, 1'b0);
    check("t2_pend7_held", pend[7], 1'b1);
    cyc(1);
    check("t2_we", rf_we, 1'b1);
    check("t2_wa", rf_wa, 5'd7);
    check("t2_wd", rf_wd, 32'h12);
    check("t2_pend7_clr", pend[7], 1'b0);

    // Fill FIFO while the pipe writes every cycle; third entry held back
    for (int i = 0; i < 3; i++) d_ent[i] = $urandom;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      drive_pipe(5'($urandom_range(1, 31)), $urandom, 1'b1);
      if (idx < 3) drive_lu(5'(10 + idx), d_ent[idx], 1'b0);
      else lu_valid = 1'b0;
      acc = lu_valid && lu_ready;
      cyc(1);
      if (acc) idx++;
    end
    check("t3_accepts", idx, 2);
    check("t3_full_ready", lu_ready, 1'b0);
    check("t3_no_stall", stall_req, 1'b0);
    pipe_we  = 1'b0;
    lu_valid = 1'b0;
    exp_q.push_back({5'd10, d_ent[0]});
    exp_q.push_back({5'd11, d_ent[1]});
    cyc(2);
    check("t3_drained_ready", lu_ready, 1'b1);

    // Starvation: one entry blocked by continuous pipe writes
    drive_pipe(5'($urandom_range(1, 31)), $urandom, 1'b1);
    wd = $urandom;
    drive_lu(5'd13, wd, 1'b0);
    cyc(1);
    lu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_pipe(5'($urandom_range(1, 31)), $urandom, 1'b1);
      cyc(1);
      if (i == 3) check("t4_stall_early", stall_req, 1'b0);
      if (i == 4) check("t4_stall_set", stall_req, 1'b1);
    end
    x_wa = 5'($urandom_range(1, 31));
    x_wd = $urandom;
    drive_pipe(x_wa, x_wd, 1'b0);
    exp_q.push_back({5'd13, wd});
    cyc(1);
    check("t4_head_wa", rf_wa, 5'd13);
    check("t4_head_wd", rf_wd, wd);
    check("t4_stall_clr", stall_req, 1'b0);
    drive_pipe(x_wa, x_wd, 1'b1);
    cyc(1);
    pipe_we = 1'b0;
    check("t4_represent_wa", rf_wa, x_wa);
    cyc(1);

    // Issue and drain of x9 on the same edge: set wins
    iss_valid = 1'b1;
    iss_wa    = 5'd9;
    cyc(1);
    iss_valid = 1'b0;
    check("t5_pend9_set", pend[9], 1'b1);
    drive_lu(5'd9, 32'hA5A5_0009, 1'b1);
    cyc(1);
    lu_valid  = 1'b0;
    iss_valid = 1'b1;
    iss_wa    = 5'd9;
    cyc(1);
    iss_valid = 1'b0;
    check("t5_pop_wa", rf_wa, 5'd9);
    check("t5_pend9_kept", pend[9], 1'b1);
    // Entry for x0 pops without a write
    drive_lu(5'd0, 32'hFFFF_0000, 1'b0);
    cyc(1);
    lu_valid = 1'b0;
    cyc(1);
    check("t5_x0_no_we", rf_we, 1'b0);
    check("t5_x0_popped", lu_ready, 1'b1);
    // Second result for x9 finally clears it
    drive_lu(5'd9, 32'h0000_0099, 1'b1);
    cyc(1);
    lu_valid = 1'b0;
    cyc(1);
    check("t5_pend9_clr", pend[9], 1'b0);

    // Reset mid-operation with two entries queued and x7/x9 pending
    iss_valid = 1'b1;
    iss_wa    = 5'd7;
    cyc(1);
    iss_wa = 5'd9;
    cyc(1);
    iss_valid = 1'b0;
    drive_pipe(5'($urandom_range(1, 31)), $urandom, 1'b1);
    drive_lu(5'd20, $urandom, 1'b0);
    cyc(1);
    drive_pipe(5'($urandom_range(1, 31)), $urandom, 1'b1);
    drive_lu(5'd21, $urandom, 1'b0);
    cyc(1);
    check("t6_pend_before", pend, 32'h0000_0280);
    check("t6_full", lu_ready, 1'b0);
    idle_inputs();
    rst = 1'b1;
    cyc(1);
    check("t6_pend_rst", pend, 32'd0);
    check("t6_we_rst", rf_we, 1'b0);
    check("t6_ready_in_rst", lu_ready, 1'b0);
    rst = 1'b0;
    cyc(1);
    check("t6_ready_after", lu_ready, 1'b1);
    check("t6_no_we", rf_we, 1'b0);
    cyc(3);

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter placed directly upstream of the pCPU register file's single write port. It merges the in-order pipeline write-back with results from long-latency units (divider, uncached load) through a small FIFO. It drives the registered `rf_we/rf_wa/rf_wd` signals into the register file. It also keeps a pending-register bitmap that the hazard logic uses to stall readers of registers still awaiting a long-latency result.

## Interface
- `WIDTH`, 32, data width of written values
- `DEPTH`, 2, long-latency result FIFO depth (power of 2, ≥2)
- `STARVE_MAX`, 4, consecutive cycles a non-empty FIFO may be blocked by the pipeline before `stall_req` asserts
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `pipe_we` in 1: pipeline write-back valid
- `pipe_wa` in 5: pipeline destination register
- `pipe_wd` in WIDTH: pipeline write data
- `lu_valid` in 1: long-latency result valid
- `lu_ready` out 1: FIFO can accept
- `lu_wa` in 5: long-latency destination register
- `lu_wd` in WIDTH: long-latency result data
- `iss_valid` in 1: a long-latency op is issued this cycle
- `iss_wa` in 5: destination register of the issued op
- `pend` out 32: pending bitmap, bit n set = xn awaits a long-latency result
- `stall_req` out 1: request pipeline to hold WB so the FIFO can drain
- `rf_we` out 1: to register file `we`
- `rf_wa` out 5: to register file `wa`
- `rf_wd` out WIDTH: to register file `wd`

## Operation
- Handshake: transfer occurs when `lu_valid && lu_ready`; the entry `{lu_wa, lu_wd}` is pushed. `lu_ready = !rst && count < DEPTH`. It does not depend on `lu_valid`. When the FIFO is full, no push occurs; push and pop in the same cycle leave `count` unchanged.
- Arbitration, evaluated each cycle (registered into `rf_*`):
  1. If `stall_req` = 1 and the FIFO is non-empty: pop the head into `rf_*`. `pipe_*` is ignored, and the pipeline re-presents it.
  2. Else if `pipe_we && pipe_wa != 0`: `rf_we` <= 1, `rf_wa/rf_wd` <= pipe. No pop.
  3. Else if the FIFO is non-empty: pop the head. `rf_we` <= (head.wa != 0); `rf_wa/rf_wd` <= head.
  4. Else `rf_we` <= 0, and `rf_wa/rf_wd` hold their previous values.
- A `pipe_we` with `pipe_wa` = 0 is a no-write; it never blocks a FIFO pop.
- Pending bitmap:
  - `iss_valid && iss_wa != 0` sets `pend[iss_wa]`.
  - Popping an entry with wa = n clears `pend[n]`.
  - If set and clear hit the same bit in the same cycle, set wins.
  - `pend[0]` is always 0.
  - Re-issuing to an already pending register keeps the bit at 1; the first drain clears it. Preventing this is the hazard logic's job.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and case 2 wins. It resets to 0 on any pop or when the FIFO is empty, and saturates at `STARVE_MAX`.
  - `stall_req` (registered) = 1 when the counter equals `STARVE_MAX`. It stays high until the cycle after a pop, then returns to 0 with the counter cleared.

## Timing
- Reset values: `rf_we`=0, `rf_wa`=0, `rf_wd`=0, `pend`=0, `stall_req`=0, `lu_ready`=0 while `rst`=1; FIFO empty, counter 0.
- `rst` mid-operation discards all FIFO contents and pending bits on that edge. No write is issued in the following cycle.
- Latency, pipeline path: `pipe_*` sampled at edge N gives `rf_*` valid after N. The register file writes at edge N+1.
- Latency, long-latency path: a push at edge N into an empty FIFO, with no pipe write, gives `rf_*` valid after edge N+1. Pass-through is not allowed, so the minimum latency is 2 edges to `rf_*`.
- `pend` updates one edge after the set or clear event. A cleared bit is visible in the same cycle that `rf_we` presents the value, so forwarding from `rf_*` is sufficient.
- FIFO order is strict FIFO; wrap-around of read/write pointers at `DEPTH` is transparent.

## Test plan
- Reset, then `pipe_we`=1, `pipe_wa`=5, `pipe_wd`=0xDEADBEEF for 1 cycle -> next cycle `rf_we`=1, `rf_wa`=5, `rf_wd`=0xDEADBEEF; following cycle `rf_we`=0.
- `iss_valid` with `iss_wa`=7, then 3 cycles later push `lu_wa`=7, `lu_wd`=0x12 with the pipeline idle -> `pend[7]`=1 from the cycle after issue; `rf_we`=1, `rf_wa`=7, `rf_wd`=0x12 two edges after the push; `pend[7]`=0 in that same cycle.
- Push 3 entries back-to-back while `pipe_we`=1 (wa≠0) every cycle -> `lu_ready`=0 after 2 accepts; the third is held by the producer; no `rf_*` carries FIFO data.
- Keep the pipe writing continuously with the FIFO holding 1 entry -> `stall_req`=1 after `STARVE_MAX`=4 blocked cycles; the next `rf_*` carries the FIFO head despite `pipe_we`=1; `stall_req`=0 one cycle later.
- Same cycle: `iss_valid` with wa=9 and pop of an entry with wa=9 -> `pend[9]` stays 1. A separate push with `lu_wa`=0 -> popped with `rf_we`=0.
- Assert `rst` with the FIFO holding 2 entries and `pend`=0x00000280 -> next cycle `pend`=0, `lu_ready`=1 after `rst` drops, and no `rf_we` pulse.
